// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch front end. It issues word-aligned fetches to an
//   in-order instruction memory and buffers the returned words in a 2-entry
//   FIFO that feeds the decode stage. Redirects (branch/jump) flush the FIFO
//   and discard the responses still in flight for the old stream.
//
//   Optional build macro: IFU_ILLEGAL_CHECK_EN
//     defined   -> id_illegal flags a head word whose low two bits are not 2'b11
//     undefined -> id_illegal is tied low and no check logic is built
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request and word-aligned address (out)
//   imem_gnt          request accepted this cycle (in)
//   imem_rvalid/rdata in-order fetch response (in)
//   redirect_valid/pc restart the fetch stream at redirect_pc (in)
//   id_valid/ready    decode handshake; id_instr/id_pc/id_illegal from FIFO head
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_illegal
);

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Request enable: keeps imem_req low until the first edge after reset.
  logic        en_q;
  logic [31:0] pc_q, pc_d;
  // Requests granted but not yet answered (including ones to be killed).
  logic [1:0]  out_q, out_d;
  // Number of upcoming responses that belong to a redirected-away stream.
  logic [1:0]  kill_q, kill_d;
  // PCs captured at grant, consumed in order as responses come back.
  logic [31:0] pcq_q [DEPTH];
  logic        pcq_wr_q, pcq_rd_q;
  // Decode-side instruction FIFO.
  ent_t        fifo_q [DEPTH];
  logic        fifo_wr_q, fifo_rd_q;
  logic [1:0]  cnt_q, cnt_d;

  logic        gnt, rsp, push, pop;
  logic [2:0]  credit;
  ent_t        head;

  // Handshake events --------------------------------------------------------
  // A response with nothing outstanding is spurious and ignored.
  assign rsp  = imem_rvalid && (out_q != 2'd0);
  assign gnt  = imem_req && imem_gnt;
  assign pop  = id_valid && id_ready;
  // Responses on a redirect cycle or while stale ones remain are dropped.
  assign push = rsp && !redirect_valid && (kill_q == 2'd0);

  // Credit counts every slot that a response could still occupy, so the FIFO
  // can never overflow. The pop term lets a draining decode stage keep the
  // request going in the same cycle (id_ready -> imem_req is combinational).
  assign credit   = {1'b0, out_q} + {1'b0, cnt_q} - {2'b00, pop};
  assign imem_req = en_q && !redirect_valid && (credit < 3'(DEPTH));
  assign imem_addr = pc_q;

  // Decode outputs ----------------------------------------------------------
  assign head     = fifo_q[fifo_rd_q];
  assign id_valid = (cnt_q != 2'd0) && !redirect_valid;
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

`ifdef IFU_ILLEGAL_CHECK_EN
  // Only 32-bit encodings (low bits 2'b11) are legal; the word still goes
  // to decode so the exception can be raised there with the right PC.
  assign id_illegal = (cnt_q != 2'd0) && (head.instr[1:0] != 2'b11);
`else
  assign id_illegal = 1'b0;
`endif

  // Next-state --------------------------------------------------------------
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + {1'b0, gnt} - {1'b0, rsp};
    kill_d = kill_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};

    if (redirect_valid) begin
      // Masking keeps the address word-aligned regardless of the low bits.
      pc_d   = redirect_pc & ~32'h3;
      // Everything still in flight after this cycle is stale; a response
      // arriving now is already accounted for by dropping it here.
      kill_d = out_q - {1'b0, rsp};
      cnt_d  = 2'd0;
    end else begin
      if (gnt) pc_d = pc_q + 32'd4;
      if (rsp && (kill_q != 2'd0)) kill_d = kill_q - 2'd1;
    end
  end

  // State -------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      pc_q      <= RESET_PC;
      out_q     <= 2'd0;
      kill_q    <= 2'd0;
      cnt_q     <= 2'd0;
      pcq_wr_q  <= 1'b0;
      pcq_rd_q  <= 1'b0;
      fifo_wr_q <= 1'b0;
      fifo_rd_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pcq_q[i]  <= '0;
        fifo_q[i] <= '0;
      end
    end else begin
      en_q   <= 1'b1;
      pc_q   <= pc_d;
      out_q  <= out_d;
      kill_q <= kill_d;
      cnt_q  <= cnt_d;

      // The PC queue tracks every outstanding request, killed or not, so it
      // is never flushed: stale entries retire as their responses return.
      if (gnt) begin
        pcq_q[pcq_wr_q] <= pc_q;
        pcq_wr_q        <= ~pcq_wr_q;
      end
      if (rsp) pcq_rd_q <= ~pcq_rd_q;

      if (redirect_valid) begin
        fifo_wr_q <= 1'b0;
        fifo_rd_q <= 1'b0;
      end else begin
        if (push) begin
          fifo_q[fifo_wr_q] <= {imem_rdata, pcq_q[pcq_rd_q]};
          fifo_wr_q         <= ~fifo_wr_q;
        end
        if (pop) fifo_rd_q <= ~fifo_rd_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_illegal;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  // Memory model: in-order responses with a latency drawn per grant.
  typedef struct {
    logic [31:0] a;
    int          t;
  } rsp_t;
  rsp_t pend[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int gnt_pct = 100, lat_min = 1, lat_max = 1, spur_pct = 0;
  int ngrant = 0, npop = 0;
  // Reference stream: next address to fetch, next PC decode should see.
  logic [31:0] exp_fetch, exp_id;
  logic        s_req, s_valid, s_ill;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h0000_4501;
    if (a == 32'h0000_0204) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic ill(input logic [31:0] w);
`ifdef IFU_ILLEGAL_CHECK_EN
    return w[1:0] != 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   imem_req,   32'd0);
    chk({tag, "_addr"},  imem_addr,  32'h0);
    chk({tag, "_valid"}, id_valid,   32'd0);
    chk({tag, "_instr"}, id_instr,   32'h0);
    chk({tag, "_pc"},    id_pc,      32'h0);
    chk({tag, "_ill"},   id_illegal, 32'd0);
  endtask

  // One clock: drive at posedge+1, check and update the model at negedge.
  task automatic cycle(input int rdy_pct, input bit redir, input logic [31:0] rpc);
    int t;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (pend.size() > 0 && pend[0].t <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend[0].a);
      void'(pend.pop_front());
    end else begin
      // Spurious rvalid only when nothing is outstanding: must be ignored.
      imem_rvalid = (pend.size() == 0) && ($urandom_range(99) < spur_pct);
      imem_rdata  = $urandom;
    end
    id_ready       = ($urandom_range(99) < rdy_pct);
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
    s_pc = id_pc; s_instr = id_instr; s_ill = id_illegal;
    if (redir) begin
      chk("redir_no_req", imem_req, 32'd0);
      chk("redir_no_valid", id_valid, 32'd0);
    end
    if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
    if (id_valid) begin
      chk("id_pc", id_pc, exp_id);
      chk("id_instr", id_instr, memf(exp_id));
      chk("id_illegal", id_illegal, ill(memf(exp_id)));
    end
    if (imem_req && imem_gnt) begin
      t = cyc + $urandom_range(lat_max, lat_min);
      pend.push_back('{a: imem_addr, t: t});
      exp_fetch = exp_fetch + 32'd4;
      ngrant++;
    end
    if (id_valid && id_ready) begin
      exp_id = exp_id + 32'd4;
      npop++;
    end
    if (redir) begin
      exp_fetch = rpc & ~32'h3;
      exp_id    = rpc & ~32'h3;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int  g0, p0;
    bit  found, got, seen_req, seen200, seen204;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    exp_fetch = 32'h0; exp_id = 32'h0;
    #2;
    chk_reset("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_before_first_edge", imem_req, 32'd0);
    @(posedge clk); #1;

    // Streaming with a 1-cycle memory: one instruction per cycle.
    for (int i = 0; i < 10; i++) begin
      cycle(100, 1'b0, '0);
      chk("stream_req", s_req, 32'd1);
      chk("stream_addr", s_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("stream_valid", s_valid, 32'd1);
        chk("stream_pc", s_pc, 32'(4 * (i - 2)));
      end
    end

    // Decode stall right after a redirect: two grants fill the credit.
    cycle(0, 1'b1, 32'h0000_0040);
    g0 = ngrant;
    for (int i = 0; i < 6; i++) cycle(0, 1'b0, '0);
    chk("stall_grants", ngrant - g0, 32'd2);
    chk("stall_req_off", s_req, 32'd0);
    chk("stall_valid", s_valid, 32'd1);
    chk("stall_head_pc", s_pc, 32'h40);
    for (int i = 0; i < 8; i++) cycle(100, 1'b0, '0);

    // Redirect with two responses in flight, unaligned target.
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() == 2) found = 1;
      else cycle(100, 1'b0, '0);
    end
    chk("two_outstanding", found, 32'd1);
    cycle(100, 1'b1, 32'h0000_0103);
    got = 0; seen_req = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(100, 1'b0, '0);
      if (s_req && !seen_req) begin
        seen_req = 1;
        chk("redir_first_addr", s_addr, 32'h100);
      end
      if (s_valid) begin
        got = 1;
        chk("redir_first_pc", s_pc, 32'h100);
      end
    end
    chk("redir_delivered", got, 32'd1);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) cycle(100, 1'b0, '0);

    // Grant withheld: request and address must hold.
    gnt_pct = 0;
    cycle(100, 1'b1, 32'h0000_0010);
    for (int i = 0; i < 3; i++) begin
      cycle(100, 1'b0, '0);
      chk("hold_req", s_req, 32'd1);
      chk("hold_addr", s_addr, 32'h10);
    end
    gnt_pct = 100;
    for (int i = 0; i < 6; i++) cycle(100, 1'b0, '0);

    // Illegal-encoding flag on specific words.
    cycle(100, 1'b1, 32'h0000_0200);
    seen200 = 0; seen204 = 0;
    for (int i = 0; i < 15 && !seen204; i++) begin
      cycle(100, 1'b0, '0);
      if (s_valid && s_pc == 32'h200) begin
        seen200 = 1;
`ifdef IFU_ILLEGAL_CHECK_EN
        chk("ill_4501", s_ill, 32'd1);
`else
        chk("ill_4501", s_ill, 32'd0);
`endif
        chk("word_4501", s_instr, 32'h0000_4501);
      end
      if (s_valid && s_pc == 32'h204) begin
        seen204 = 1;
        chk("ill_0013", s_ill, 32'd0);
      end
    end
    chk("ill_words_seen", {seen200, seen204}, 32'd3);

    // Address wrap at the top of the space.
    cycle(100, 1'b1, 32'hFFFF_FFF8);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(100, 1'b0, '0);
      if (s_valid && s_pc == 32'h0) found = 1;
    end
    chk("wrap_to_zero", found, 32'd1);

    // Randomised traffic against the stream model.
    gnt_pct = 70; lat_min = 1; lat_max = 4; spur_pct = 20;
    p0 = npop;
    for (int i = 0; i < 2000; i++) begin
      found = ($urandom_range(99) < 5);
      cycle(60, found, $urandom);
    end
    chk("rand_progress", (npop - p0) > 100, 32'd1);

    // Reset in the middle of traffic; memory side resets too.
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    pend.delete();
    exp_fetch = 32'h0; exp_id = 32'h0;
    gnt_pct = 100; lat_min = 1; lat_max = 1; spur_pct = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_before_edge", imem_req, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      cycle(100, 1'b0, '0);
      chk("midrst_addr", s_addr, 32'(4 * i));
      if (i >= 2) chk("midrst_pc", s_pc, 32'(4 * (i - 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: imem_req  output  1  fetch request to instruction memory.
REQ-005 Port: imem_addr  output  32  word-aligned fetch address.
REQ-006 Port: imem_gnt  input  1  request accepted this cycle.
REQ-007 Port: imem_rvalid  input  1  in-order fetch response valid.
REQ-008 Port: imem_rdata  input  32  fetched instruction word.
REQ-009 Port: redirect_valid  input  1  redirect fetch stream (branch/jump).
REQ-010 Port: redirect_pc  input  32  new fetch address.
REQ-011 Port: id_valid  output  1  instruction available to decode stage.
REQ-012 Port: id_ready  input  1  decode stage accepts instruction.
REQ-013 Port: id_instr  output  32  instruction word; id_instr[6:0] is the decoder opcode.
REQ-014 Port: id_pc  output  32  PC of id_instr.
REQ-015 Port: id_illegal  output  1  instruction not a 32-bit encoding (see Configuration).

Function
REQ-016 Memory handshake: request transferred on a cycle with imem_req=1 and imem_gnt=1; imem_addr held stable while imem_req=1 and imem_gnt=0.
REQ-017 Responses arrive in request order, earliest one cycle after grant; one response per granted request.
REQ-018 Fetch PC advances by 4 on each grant, 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 2-entry instruction FIFO stores {instr, pc}; id_instr/id_pc/id_illegal driven from FIFO head, id_valid = FIFO non-empty and redirect_valid=0.
REQ-020 Pop on id_valid & id_ready; head fields stable while id_valid=1 and id_ready=0.
REQ-021 Credit rule: imem_req = !redirect_valid && (outstanding + fifo_count - pop) < 2; combinational path id_ready -> imem_req permitted.
REQ-022 Credit rule guarantees no FIFO overflow; sustained throughput one instruction/cycle with 1-cycle memory and id_ready=1.
REQ-023 Redirect: same cycle, FIFO flushed, no pop, no request; next cycle fetch PC = {redirect_pc[31:2], 2'b00}.
REQ-024 Redirect sets kill count = outstanding - (imem_rvalid ? 1 : 0); response arriving on redirect cycle discarded.
REQ-025 Responses while kill count > 0 discarded and decrement it; otherwise pushed into FIFO with the PC captured at grant.
REQ-026 Back-to-back redirects: later redirect wins; kill count recomputed per REQ-024.
REQ-027 imem_rvalid with outstanding = 0 ignored.
REQ-028 Redirect with FIFO empty and nothing outstanding: only PC updates.

Reset
REQ-029 rst_n low asynchronously: fetch PC = RESET_PC, FIFO empty, outstanding = 0, kill = 0.
REQ-030 Outputs during reset: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_illegal=0.
REQ-031 First imem_req asserted on first rising clk edge after rst_n deasserts; reset mid-operation discards all in-flight state; memory side is reset with this block.

Configuration
REQ-032 Macro IFU_ILLEGAL_CHECK_EN defined: id_illegal = 1 when head instr[1:0] != 2'b11; instruction still delivered normally.
REQ-033 Macro undefined: id_illegal tied 0, no check logic.

Verification
REQ-034 Reset release, 1-cycle memory, id_ready=1 -> addrs 0x0,0x4,0x8 on consecutive cycles; id_valid continuous from cycle 2, id_pc 0x0,0x4,0x8.
REQ-035 id_ready=0 for 6 cycles -> exactly 2 grants, id_instr/id_pc frozen, imem_req=0 after credit exhausted; resume with no loss or duplication.
REQ-036 Two outstanding, redirect_pc=0x0000_0103 -> both stale responses dropped, next imem_addr=0x0000_0100, first id_pc=0x100.
REQ-037 imem_gnt low 3 cycles on addr 0x10 -> imem_addr stays 0x10, imem_req stays 1.
REQ-038 Macro defined, fetched word 0x0000_4501 -> id_illegal=1; word 0x0000_0013 -> id_illegal=0; macro undefined -> always 0.
